julia_pixel_scheduler: RTL and testbench

JULIA_PIXEL_SCHEDULER -- requirements
Module: julia_pixel_scheduler

---
 rtl/julia_pixel_scheduler.sv | 135 +++++++++++++
 tb/tb_julia_pixel_scheduler.sv | 175 +++++++++++++++++
 2 files changed

// File: rtl/julia_pixel_scheduler.sv
// julia_pixel_scheduler: round-robin pixel dispatch to iteration engines with
// in-order retire into an AXI4-Stream colour output.
module julia_pixel_scheduler #(
  parameter int NUM_ENGINES = 4,
  parameter int X_SIZE      = 640,
  parameter int Y_SIZE      = 480
) (
  input  logic                     out_stream_aclk,
  input  logic                     periph_resetn,
  input  logic                     cfg_enable,
  output logic [NUM_ENGINES-1:0]   eng_start,
  output logic [9:0]               eng_px,
  output logic [8:0]               eng_py,
  input  logic [NUM_ENGINES-1:0]   eng_done,
  input  logic [8*NUM_ENGINES-1:0] eng_iter,
  output logic [31:0]              out_stream_tdata,
  output logic                     out_stream_tvalid,
  input  logic                     out_stream_tready,
  output logic                     out_stream_tlast,
  output logic                     out_stream_tuser,
  output logic [3:0]               out_stream_tkeep,
  output logic                     frame_done
);
  localparam int DW = $clog2(NUM_ENGINES);
  localparam logic [9:0] XL = 10'(X_SIZE - 1);
  localparam logic [8:0] YL = 9'(Y_SIZE - 1);
  localparam logic [NUM_ENGINES-1:0] ONE = 1;
  typedef enum logic [1:0] {F_IDLE, F_RUN, F_DRAIN} fsm_t;
  typedef enum logic [1:0] {S_IDLE, S_RUN, S_HELD} slot_t;
  fsm_t                   fsm_q;
  slot_t                  slot_q [NUM_ENGINES];
  logic [7:0]             iter_q [NUM_ENGINES];
  logic [DW-1:0]          dp_q, rp_q;
  logic [9:0]             ix_q, ox_q, eng_px_q;
  logic [8:0]             iy_q, oy_q, eng_py_q;
  logic [NUM_ENGINES-1:0] eng_start_q;
  logic [31:0]            tdata_q;
  logic                   tvalid_q, tlast_q, tuser_q, frame_done_q;
  logic                   start, disp, last_issue, accept, ret, out_last;
  logic [9:0]             cx, ax, lx;
  logic [8:0]             cy, ay, ly;
  logic [7:0]             rit;
  logic [31:0]            colour;
  // The frame-start cycle dispatches pixel (0,0) directly so the first start pulse follows enable by one cycle.
  always_comb begin
    start      = fsm_q == F_IDLE && cfg_enable;
    cx         = start ? '0 : ix_q;
    cy         = start ? '0 : iy_q;
    disp       = (start || fsm_q == F_RUN) && slot_q[dp_q] == S_IDLE;
    last_issue = cx == XL && cy == YL;
    accept     = tvalid_q && out_stream_tready;
    ret        = slot_q[rp_q] == S_HELD && (!tvalid_q || out_stream_tready);
    out_last   = ox_q == XL && oy_q == YL;
    ax         = ox_q == XL ? '0 : ox_q + 10'd1;
    ay         = ox_q != XL ? oy_q : (oy_q == YL ? '0 : oy_q + 9'd1);
    lx         = accept ? ax : ox_q;
    ly         = accept ? ay : oy_q;
    rit        = iter_q[rp_q];
    colour     = rit == 8'hFF ? '0 : {8'h00, rit, rit << 1, 8'(rit * 2'd3)};
  end
  always_ff @(posedge out_stream_aclk or negedge periph_resetn) begin
    if (!periph_resetn) begin
      fsm_q        <= F_IDLE;
      dp_q         <= '0;
      rp_q         <= '0;
      ix_q         <= '0;
      iy_q         <= '0;
      ox_q         <= '0;
      oy_q         <= '0;
      eng_start_q  <= '0;
      eng_px_q     <= '0;
      eng_py_q     <= '0;
      tdata_q      <= '0;
      tvalid_q     <= 1'b0;
      tlast_q      <= 1'b0;
      tuser_q      <= 1'b0;
      frame_done_q <= 1'b0;
      for (int i = 0; i < NUM_ENGINES; i++) begin
        slot_q[i] <= S_IDLE;
        iter_q[i] <= '0;
      end
    end else begin
      eng_start_q <= disp ? ONE << dp_q : '0;
      if (disp) begin
        eng_px_q <= cx;
        eng_py_q <= cy;
        ix_q     <= cx == XL ? '0 : cx + 10'd1;
        iy_q     <= cx == XL ? cy + 9'd1 : cy;
        dp_q     <= dp_q + 1'b1;
      end else if (start) begin
        ix_q <= '0;
        iy_q <= '0;
      end
      if (ret)
        rp_q <= rp_q + 1'b1;
      for (int i = 0; i < NUM_ENGINES; i++)
        if (disp && dp_q == DW'(i))
          slot_q[i] <= S_RUN;
        else if (eng_done[i] && slot_q[i] == S_RUN) begin
          slot_q[i] <= S_HELD;
          iter_q[i] <= eng_iter[8*i +: 8];
        end else if (ret && rp_q == DW'(i))
          slot_q[i] <= S_IDLE;
      if (start) begin
        ox_q <= '0;
        oy_q <= '0;
      end else if (accept) begin
        ox_q <= ax;
        oy_q <= ay;
      end
      tvalid_q <= ret || (tvalid_q && !out_stream_tready);
      if (ret) begin
        tdata_q <= colour;
        tlast_q <= lx == XL;
        tuser_q <= lx == '0 && ly == '0;
      end
      frame_done_q <= fsm_q == F_DRAIN && accept && out_last;
      if (start)
        fsm_q <= disp && last_issue ? F_DRAIN : F_RUN;
      else if (fsm_q == F_RUN && disp && last_issue)
        fsm_q <= F_DRAIN;
      else if (fsm_q == F_DRAIN && accept && out_last)
        fsm_q <= F_IDLE;
    end
  end
  assign eng_start         = eng_start_q;
  assign eng_px            = eng_px_q;
  assign eng_py            = eng_py_q;
  assign out_stream_tdata  = tdata_q;
  assign out_stream_tvalid = tvalid_q;
  assign out_stream_tlast  = tlast_q;
  assign out_stream_tuser  = tuser_q;
  assign out_stream_tkeep  = 4'hF;
  assign frame_done        = frame_done_q;
endmodule

// File: tb/tb_julia_pixel_scheduler.sv
// tb_julia_pixel_scheduler: engine model plus raster-order scoreboard for the pixel scheduler.
module tb_julia_pixel_scheduler;
  localparam int N = 4, XS = 4, YS = 2, NPIX = XS * YS;
  logic clk = 1'b0, rst_n = 1'b0, en = 1'b0, tready = 1'b1;
  logic [N-1:0] eng_start, eng_done = '0;
  logic [9:0] px;
  logic [8:0] py;
  logic [8*N-1:0] eng_iter = '0;
  logic [31:0] tdata;
  logic tvalid, tlast, tuser, fd;
  logic [3:0] tkeep;

  julia_pixel_scheduler #(.NUM_ENGINES(N), .X_SIZE(XS), .Y_SIZE(YS)) dut (
    .out_stream_aclk(clk), .periph_resetn(rst_n), .cfg_enable(en),
    .eng_start(eng_start), .eng_px(px), .eng_py(py), .eng_done(eng_done), .eng_iter(eng_iter),
    .out_stream_tdata(tdata), .out_stream_tvalid(tvalid), .out_stream_tready(tready),
    .out_stream_tlast(tlast), .out_stream_tuser(tuser), .out_stream_tkeep(tkeep),
    .frame_done(fd)
  );

  always #5 clk = ~clk;

  typedef struct {logic [33:0] v; int e;} exp_t;
  exp_t sb[$];
  int n_vec = 0, n_err = 0;
  int lat[N], cnt[N];
  logic busy[N];
  logic [7:0] itab[NPIX] = '{8'hFF, 8'h10, 8'h90, 8'h01, 8'h7F, 8'h80, 8'hFE, 8'h00};
  int ex, ey, edp, starts, beats, fdone, stall_left;
  logic prev_hold;
  logic [33:0] prev_out;

  task automatic check(string tag, logic [33:0] got, logic [33:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] colour(logic [7:0] it);
    int v = int'(it);
    return it == 8'hFF ? 32'h0 : {8'h00, it, 8'((v * 2) % 256), 8'((v * 3) % 256)};
  endfunction

  task automatic clear_model();
    sb.delete();
    for (int i = 0; i < N; i++) begin
      cnt[i] = 0;
      busy[i] = 1'b0;
    end
    eng_done = '0;
    eng_iter = '0;
    ex = 0; ey = 0; edp = 0; starts = 0; beats = 0; stall_left = 0;
    prev_hold = 1'b0;
    tready = 1'b1;
  endtask

  task automatic monitor();
    exp_t h;
    if (!rst_n) return;
    for (int i = 0; i < N; i++) begin
      eng_done[i] = 1'b0;
      if (cnt[i] > 0) begin
        cnt[i]--;
        eng_done[i] = cnt[i] == 0;
      end
    end
    if (eng_start != '0) begin
      check("start_bit", 34'(eng_start), 34'(1 << edp));
      check("start_xy", 34'({px, py}), 34'({10'(ex), 9'(ey)}));
      check("start_free", 34'(busy[edp]), 34'(0));
      check("start_cnt", 34'(starts < NPIX), 34'(1));
      busy[edp] = 1'b1;
      cnt[edp] = lat[edp];
      eng_iter[8*edp +: 8] = itab[ey*XS+ex];
      sb.push_back(exp_t'{v: {colour(itab[ey*XS+ex]), ex == XS - 1, ex == 0 && ey == 0}, e: edp});
      starts++;
      edp = (edp + 1) % N;
      ex++;
      if (ex == XS) begin
        ex = 0;
        ey = (ey + 1) % YS;
      end
    end
    if (tvalid) begin
      if (prev_hold) check("hold", {tdata, tlast, tuser}, prev_out);
      if (sb.size() > 0) busy[sb[0].e] = 1'b0;
      if (tready) begin
        if (sb.size() == 0) check("spurious_beat", 34'(1), 34'(0));
        else begin
          h = sb.pop_front();
          check("beat", {tdata, tlast, tuser}, h.v);
        end
        beats++;
      end
    end
    if (fd) begin
      fdone++;
      check("fd_beats", 34'(beats), 34'(NPIX));
      beats = 0;
      starts = 0;
    end
    tready = stall_left == 0;
    if (stall_left > 0) stall_left--;
    prev_hold = tvalid && !tready;
    prev_out = {tdata, tlast, tuser};
  endtask

  task automatic tick();
    @(negedge clk);
    monitor();
  endtask

  task automatic check_reset_outputs();
    check("rst_ctl", 34'({eng_start, px, py, tvalid, tlast, tuser, fd}), 34'(0));
    check("rst_tdata", 34'(tdata), 34'(0));
    check("rst_tkeep", 34'(tkeep), 34'(4'hF));
  endtask

  task automatic do_reset();
    #1 rst_n = 1'b0;
    #1 check_reset_outputs();
    en = 1'b0;
    clear_model();
    repeat (2) tick();
    rst_n = 1'b1;
  endtask

  task automatic do_frame(int drop_after, int stall_at, int rst_at);
    int f0 = fdone;
    bit stalled = 1'b0;
    en = 1'b1;
    tick();
    check("first_start", 34'(eng_start), 34'(1));
    for (int t = 0; t < 400 && fdone == f0; t++) begin
      if (starts >= drop_after) en = 1'b0;
      if (beats == stall_at && !stalled) begin
        stall_left = 5;
        stalled = 1'b1;
      end
      if (beats == rst_at) begin
        do_reset();
        return;
      end
      tick();
    end
    check("frame_done", 34'(fdone - f0), 34'(1));
    check("sb_empty", 34'(sb.size()), 34'(0));
    repeat (8) tick();
    check("idle_quiet", 34'({starts, fdone - f0}), 34'({32'd0, 32'd1}));
  endtask

  initial begin
    fdone = 0;
    for (int i = 0; i < N; i++) lat[i] = 3;
    clear_model();
    repeat (2) tick();
    check_reset_outputs();
    rst_n = 1'b1;
    tick();
    do_frame(1, -1, -1);
    lat = '{6, 1, 3, 3};
    do_frame(1, -1, -1);
    lat = '{3, 3, 3, 3};
    do_frame(1, 2, -1);
    do_frame(3, -1, -1);
    do_frame(1, -1, 4);
    do_frame(1, -1, -1);
    for (int i = 0; i < N; i++) lat[i] = int'($urandom_range(1, 7));
    do_frame(1, 3, -1);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
